// File: rtl/pc_update_sequencer_pkg.sv
// Shared encodings for the PC update sequencer: request kinds, PC-source
// selects, exception causes and FSM states.
package pc_update_sequencer_pkg;

  typedef enum logic [2:0] {
    KIND_SEQ    = 3'd0,
    KIND_JUMP   = 3'd1,
    KIND_JR     = 3'd2,
    KIND_BRANCH = 3'd3,
    KIND_RTE    = 3'd4
  } req_kind_t;

  typedef enum logic [2:0] {
    SEL_ALU_RESULT = 3'b000,
    SEL_JUMP       = 3'b001,
    SEL_MEM_DATA   = 3'b010,
    SEL_ALU_OUT    = 3'b011,
    SEL_EPC        = 3'b100
  } pc_sel_t;

  typedef enum logic [1:0] {
    CAUSE_NONE   = 2'd0,
    CAUSE_OPCODE = 2'd1,
    CAUSE_OVF    = 2'd2,
    CAUSE_DIV0   = 2'd3
  } cause_t;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ISSUE    = 3'd1,
    ST_EXC_EPC  = 3'd2,
    ST_EXC_RD   = 3'd3,
    ST_EXC_WAIT = 3'd4,
    ST_EXC_LOAD = 3'd5
  } state_t;

  // Fixed exception priority: opcode over overflow over divide-by-zero.
  function automatic cause_t pick_cause(input logic opcode, input logic ovf, input logic div0);
    if (opcode) begin
      return CAUSE_OPCODE;
    end else if (ovf) begin
      return CAUSE_OVF;
    end else if (div0) begin
      return CAUSE_DIV0;
    end else begin
      return CAUSE_NONE;
    end
  endfunction

endpackage

// File: rtl/pc_update_sequencer.sv
// Sequences every PC change of the multicycle core, including the
// multi-cycle exception entry (save EPC, fetch vector word, load PC).
module pc_update_sequencer
  import pc_update_sequencer_pkg::*;
#(
  parameter int         MEM_WAIT   = 1,
  parameter logic [7:0] VEC_OPCODE = 8'd253,
  parameter logic [7:0] VEC_OVF    = 8'd254,
  parameter logic [7:0] VEC_DIV0   = 8'd255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  input  logic [2:0] req_kind,
  input  logic       branch_taken,
  input  logic       exc_opcode,
  input  logic       exc_ovf,
  input  logic       exc_div0,
  output logic       req_ready,
  output logic [2:0] pc_source_sel,
  output logic       pc_write,
  output logic       epc_write,
  output logic       vec_read,
  output logic [7:0] vec_addr,
  output logic [1:0] exc_cause,
  output logic       exc_ack,
  output logic       done
);

  localparam logic [2:0] WAIT_INIT = 3'(MEM_WAIT - 1);

  state_t     state;
  logic [2:0] wait_cnt;
  logic [7:0] vec_target;
  logic       exc_any_s;
  cause_t     cause_s;
  logic [7:0] vec_s;

  // Resolve the highest-priority pending exception and its vector address.
  always_comb begin
    exc_any_s = exc_opcode | exc_ovf | exc_div0;
    cause_s   = pick_cause(exc_opcode, exc_ovf, exc_div0);
    case (cause_s)
      CAUSE_OPCODE: vec_s = VEC_OPCODE;
      CAUSE_OVF:    vec_s = VEC_OVF;
      CAUSE_DIV0:   vec_s = VEC_DIV0;
      default:      vec_s = 8'd0;
    endcase
  end

  // Sequencer FSM; outputs are registered and pulses default low each cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= ST_IDLE;
      wait_cnt      <= 3'd0;
      vec_target    <= 8'd0;
      req_ready     <= 1'b1;
      pc_source_sel <= SEL_ALU_RESULT;
      pc_write      <= 1'b0;
      epc_write     <= 1'b0;
      vec_read      <= 1'b0;
      vec_addr      <= 8'd0;
      exc_cause     <= CAUSE_NONE;
      exc_ack       <= 1'b0;
      done          <= 1'b0;
    end else begin
      pc_write  <= 1'b0;
      epc_write <= 1'b0;
      vec_read  <= 1'b0;
      exc_ack   <= 1'b0;
      done      <= 1'b0;
      case (state)
        ST_IDLE: begin
          // Exceptions win; a simultaneous request is dropped and reissued by control.
          if (exc_any_s) begin
            state      <= ST_EXC_EPC;
            req_ready  <= 1'b0;
            exc_ack    <= 1'b1;
            exc_cause  <= cause_s;
            vec_target <= vec_s;
          end else if (req_valid) begin
            state     <= ST_ISSUE;
            req_ready <= 1'b0;
            done      <= 1'b1;
            case (req_kind)
              KIND_SEQ: begin
                pc_source_sel <= SEL_ALU_RESULT;
                pc_write      <= 1'b1;
              end
              KIND_JUMP: begin
                pc_source_sel <= SEL_JUMP;
                pc_write      <= 1'b1;
              end
              KIND_JR: begin
                pc_source_sel <= SEL_ALU_OUT;
                pc_write      <= 1'b1;
              end
              KIND_BRANCH: begin
                pc_source_sel <= SEL_ALU_OUT;
                pc_write      <= branch_taken;
              end
              KIND_RTE: begin
                pc_source_sel <= SEL_EPC;
                pc_write      <= 1'b1;
              end
              default: begin
                pc_write <= 1'b0;
              end
            endcase
          end else begin
            req_ready <= 1'b1;
          end
        end
        ST_ISSUE: begin
          state     <= ST_IDLE;
          req_ready <= 1'b1;
        end
        ST_EXC_EPC: begin
          state     <= ST_EXC_RD;
          epc_write <= 1'b1;
        end
        ST_EXC_RD: begin
          state    <= ST_EXC_WAIT;
          vec_read <= 1'b1;
          vec_addr <= vec_target;
          wait_cnt <= WAIT_INIT;
        end
        ST_EXC_WAIT: begin
          // Counter already at zero means memData is valid next cycle.
          if (wait_cnt == 3'd0) begin
            state         <= ST_EXC_LOAD;
            pc_source_sel <= SEL_MEM_DATA;
            pc_write      <= 1'b1;
            done          <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt - 3'd1;
          end
        end
        ST_EXC_LOAD: begin
          state     <= ST_IDLE;
          req_ready <= 1'b1;
        end
        default: begin
          state     <= ST_IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_update_sequencer.sv
// Directed scoreboard bench for pc_update_sequencer with MEM_WAIT=2.
module tb_pc_update_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_valid;
  logic [2:0] req_kind;
  logic       branch_taken;
  logic       exc_opcode;
  logic       exc_ovf;
  logic       exc_div0;
  logic       req_ready;
  logic [2:0] pc_source_sel;
  logic       pc_write;
  logic       epc_write;
  logic       vec_read;
  logic [7:0] vec_addr;
  logic [1:0] exc_cause;
  logic       exc_ack;
  logic       done;

  typedef struct {
    string       tag;
    logic [18:0] v;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  pc_update_sequencer #(
    .MEM_WAIT  (2),
    .VEC_OPCODE(8'd253),
    .VEC_OVF   (8'd254),
    .VEC_DIV0  (8'd255)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_kind     (req_kind),
    .branch_taken (branch_taken),
    .exc_opcode   (exc_opcode),
    .exc_ovf      (exc_ovf),
    .exc_div0     (exc_div0),
    .req_ready    (req_ready),
    .pc_source_sel(pc_source_sel),
    .pc_write     (pc_write),
    .epc_write    (epc_write),
    .vec_read     (vec_read),
    .vec_addr     (vec_addr),
    .exc_cause    (exc_cause),
    .exc_ack      (exc_ack),
    .done         (done)
  );

  always #5 clk = ~clk;

  // Queue the expected output set for the next checked cycle.
  task automatic expect_out(input string tag, input logic rdy, input logic [2:0] sel,
                            input logic pw, input logic ew, input logic vr,
                            input logic [7:0] va, input logic [1:0] cause,
                            input logic ack, input logic dn);
    exp_t e;
    e.tag = tag;
    e.v   = {rdy, sel, pw, ew, vr, va, cause, ack, dn};
    q.push_back(e);
  endtask

  // Advance one clock, then compare against the oldest queued expectation.
  task automatic tick();
    exp_t        e;
    logic [18:0] obs;
    @(posedge clk);
    #1;
    if (q.size() > 0) begin
      e   = q.pop_front();
      obs = {req_ready, pc_source_sel, pc_write, epc_write, vec_read, vec_addr,
             exc_cause, exc_ack, done};
      total++;
      assert (obs === e.v) else begin
        bad++;
        $error("FAIL %s: observed=%05h expected=%05h (rdy,sel,pw,ew,vr,va,cause,ack,done)",
               e.tag, obs, e.v);
      end
    end
  endtask

  task automatic request(input string tag, input logic [2:0] kind, input logic taken,
                         input logic [2:0] sel_exp, input logic pw_exp,
                         input logic [7:0] va_hold, input logic [1:0] cause_hold);
    req_valid    = 1'b1;
    req_kind     = kind;
    branch_taken = taken;
    expect_out({tag, "_issue"}, 1'b0, sel_exp, pw_exp, 1'b0, 1'b0, va_hold, cause_hold, 1'b0, 1'b1);
    tick();
    req_valid    = 1'b0;
    branch_taken = 1'b0;
    expect_out({tag, "_idle"}, 1'b1, sel_exp, 1'b0, 1'b0, 1'b0, va_hold, cause_hold, 1'b0, 1'b0);
    tick();
  endtask

  initial begin
    reset        = 1'b1;
    req_valid    = 1'b0;
    req_kind     = 3'd0;
    branch_taken = 1'b0;
    exc_opcode   = 1'b0;
    exc_ovf      = 1'b0;
    exc_div0     = 1'b0;

    tick();
    expect_out("reset_state", 1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 8'd0, 2'd0, 1'b0, 1'b0);
    tick();
    reset = 1'b0;
    expect_out("idle_after_reset", 1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 8'd0, 2'd0, 1'b0, 1'b0);
    tick();

    request("seq",       3'd0, 1'b0, 3'b000, 1'b1, 8'd0, 2'd0);
    request("jump",      3'd1, 1'b0, 3'b001, 1'b1, 8'd0, 2'd0);
    request("jr",        3'd2, 1'b0, 3'b011, 1'b1, 8'd0, 2'd0);
    request("rte",       3'd4, 1'b0, 3'b100, 1'b1, 8'd0, 2'd0);
    request("reserved6", 3'd6, 1'b1, 3'b100, 1'b0, 8'd0, 2'd0);
    request("br_nt",     3'd3, 1'b0, 3'b011, 1'b0, 8'd0, 2'd0);
    request("br_t",      3'd3, 1'b1, 3'b011, 1'b1, 8'd0, 2'd0);

    // Overflow and div0 together with a request: overflow wins, request dropped.
    exc_ovf   = 1'b1;
    exc_div0  = 1'b1;
    req_valid = 1'b1;
    req_kind  = 3'd0;
    expect_out("ovf_ack", 1'b0, 3'b011, 1'b0, 1'b0, 1'b0, 8'd0, 2'd2, 1'b1, 1'b0);
    tick();
    exc_ovf   = 1'b0;
    exc_div0  = 1'b0;
    req_valid = 1'b0;
    expect_out("ovf_epc",  1'b0, 3'b011, 1'b0, 1'b1, 1'b0, 8'd0,   2'd2, 1'b0, 1'b0);
    expect_out("ovf_rd",   1'b0, 3'b011, 1'b0, 1'b0, 1'b1, 8'd254, 2'd2, 1'b0, 1'b0);
    expect_out("ovf_wait", 1'b0, 3'b011, 1'b0, 1'b0, 1'b0, 8'd254, 2'd2, 1'b0, 1'b0);
    expect_out("ovf_load", 1'b0, 3'b010, 1'b1, 1'b0, 1'b0, 8'd254, 2'd2, 1'b0, 1'b1);
    expect_out("ovf_idle", 1'b1, 3'b010, 1'b0, 1'b0, 1'b0, 8'd254, 2'd2, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) tick();

    // Opcode exception raised during ISSUE is only taken back in IDLE.
    req_valid = 1'b1;
    req_kind  = 3'd0;
    expect_out("opc_issue", 1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 8'd254, 2'd2, 1'b0, 1'b1);
    tick();
    req_valid  = 1'b0;
    exc_opcode = 1'b1;
    expect_out("opc_ignored", 1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 8'd254, 2'd2, 1'b0, 1'b0);
    expect_out("opc_ack",     1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 8'd254, 2'd1, 1'b1, 1'b0);
    tick();
    tick();
    exc_opcode = 1'b0;
    expect_out("opc_epc",  1'b0, 3'b000, 1'b0, 1'b1, 1'b0, 8'd254, 2'd1, 1'b0, 1'b0);
    expect_out("opc_rd",   1'b0, 3'b000, 1'b0, 1'b0, 1'b1, 8'd253, 2'd1, 1'b0, 1'b0);
    expect_out("opc_wait", 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 8'd253, 2'd1, 1'b0, 1'b0);
    expect_out("opc_load", 1'b0, 3'b010, 1'b1, 1'b0, 1'b0, 8'd253, 2'd1, 1'b0, 1'b1);
    expect_out("opc_idle", 1'b1, 3'b010, 1'b0, 1'b0, 1'b0, 8'd253, 2'd1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) tick();

    // Div0 entry aborted by reset while waiting on memory.
    exc_div0 = 1'b1;
    expect_out("div0_ack", 1'b0, 3'b010, 1'b0, 1'b0, 1'b0, 8'd253, 2'd3, 1'b1, 1'b0);
    tick();
    exc_div0 = 1'b0;
    expect_out("div0_epc", 1'b0, 3'b010, 1'b0, 1'b1, 1'b0, 8'd253, 2'd3, 1'b0, 1'b0);
    expect_out("div0_rd",  1'b0, 3'b010, 1'b0, 1'b0, 1'b1, 8'd255, 2'd3, 1'b0, 1'b0);
    tick();
    tick();
    reset = 1'b1;
    expect_out("abort_reset", 1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 8'd0, 2'd0, 1'b0, 1'b0);
    tick();
    reset = 1'b0;
    expect_out("abort_no_write", 1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 8'd0, 2'd0, 1'b0, 1'b0);
    tick();
    request("post_reset_jump", 3'd1, 1'b0, 3'b001, 1'b1, 8'd0, 2'd0);

    total++;
    assert (q.size() == 0) else begin
      bad++;
      $error("FAIL scoreboard_drain: observed=%0d expected=0 leftover entries", q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_update_sequencer.md
Name: pc_update_sequencer

Overview:
- Sequences every PC change in the multicycle core.
- Drives the PC-source mux select (3-bit), the PC write enable, the EPC write enable and the exception-vector memory read.
- Accepts one PC-update request at a time from the main control FSM.
- Runs the multi-cycle exception entry: save EPC, read vector word from memory, load PC from memory data.

Parameters:
- MEM_WAIT, 1, memory read latency in cycles between vec_read issue and valid memData (legal 1..7).
- VEC_OPCODE, 8'd253, byte address of the invalid-opcode vector word.
- VEC_OVF, 8'd254, byte address of the overflow vector word.
- VEC_DIV0, 8'd255, byte address of the divide-by-zero vector word.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  control FSM requests a PC update.
- req_kind  in  3  0=SEQ (PC+4), 1=JUMP, 2=JR, 3=BRANCH, 4=RTE; 5..7 reserved.
- branch_taken  in  1  branch condition, sampled with req_valid when req_kind=BRANCH.
- exc_opcode  in  1  invalid-opcode exception, level, held until exc_ack.
- exc_ovf  in  1  ALU overflow exception, level, held until exc_ack.
- exc_div0  in  1  divide-by-zero exception, level, held until exc_ack.
- req_ready  out  1  high only in IDLE.
- pc_source_sel  out  3  mux select: 000 aluResult, 001 jump concat, 010 memData, 011 aluOut, 100 epc.
- pc_write  out  1  PC register load enable.
- epc_write  out  1  EPC load enable; EPC datapath input is PC-4 on aluResult.
- vec_read  out  1  memory read strobe for the vector word.
- vec_addr  out  8  vector byte address, valid while vec_read=1.
- exc_cause  out  2  0 none, 1 opcode, 2 overflow, 3 div0; held until next exception.
- exc_ack  out  1  one-cycle pulse when an exception is accepted.
- done  out  1  one-cycle pulse when the request or exception entry completes.

Behaviour:
- All outputs are registered.
- Reset values: state IDLE, pc_source_sel=000, all enables and pulses 0, vec_addr=0, exc_cause=0.
- Reset mid-operation aborts the sequence with no further writes.
- States: IDLE, ISSUE, EXC_EPC, EXC_RD, EXC_WAIT, EXC_LOAD.
- IDLE, exception pending (any exc_* high):
  - Accept the exception; exceptions win over a simultaneous req_valid.
  - Priority among exceptions: opcode > ovf > div0.
  - Latch cause and vector address, pulse exc_ack, go to EXC_EPC.
  - The unaccepted req_valid is ignored; control reissues it.
- IDLE, req_valid=1, no exception: latch kind/branch_taken, go to ISSUE.
- ISSUE (exactly 1 cycle, accept at T means effects at T+1): set select per kind and pulse done, then IDLE.
  - SEQ: sel=000, pc_write=1.
  - JUMP: sel=001, pc_write=1.
  - JR: sel=011, pc_write=1.
  - RTE: sel=100, pc_write=1.
  - BRANCH: sel=011; pc_write=branch_taken.
  - Reserved kinds: pc_write=0, select unchanged.
  - done pulses in every case.
- EXC_EPC (1 cycle): epc_write=1, pc_write=0.
- EXC_RD (1 cycle): vec_read=1, vec_addr=latched vector. Load a wait counter with MEM_WAIT-1.
- EXC_WAIT: hold vec_addr and decrement the counter; leave when it reaches 0. The MEM_WAIT=1 case takes 0 cycles here.
- EXC_LOAD (1 cycle): sel=010, pc_write=1, done=1, then IDLE.
- Exception entry latency, accept to PC write: 3+MEM_WAIT-1 cycles after exc_ack.
- exc_* inputs are ignored outside IDLE. req_ready=0 outside IDLE.
- pc_write and epc_write are never high in the same cycle.

Decomposition:
- Shared package holds:
  - req_kind encodings.
  - PC-source select encodings 000..100.
  - cause codes.
  - state enumeration.
- Sub-module: none. The wait counter is a 3-bit register inside the FSM.

Test Plan:
- Reset asserted mid EXC_WAIT -> next cycle IDLE, pc_write=0, exc_cause=0, req_ready=1.
- req_valid=1, kind=SEQ at T -> T+1: sel=000, pc_write=1, done=1; T+2: req_ready=1.
- kind=BRANCH, branch_taken=0 -> sel=011, pc_write=0, done=1. Repeat with taken=1 -> pc_write=1.
- kind=RTE -> sel=100, pc_write=1. kind=6 -> pc_write=0, done=1.
- exc_ovf=1 and exc_div0=1 together with req_valid=1, MEM_WAIT=2 -> exc_ack, cause=2, then:
  - T+1: epc_write=1.
  - T+2: vec_read=1, vec_addr=254.
  - T+3: wait.
  - T+4: sel=010, pc_write=1, done=1.
  - The request is not serviced.
- exc_opcode raised during ISSUE -> ignored that cycle, accepted on return to IDLE, vec_addr=253, cause=1.
